// File: rtl/la_cmd_sequencer.sv
// Logic-analyzer command sequencer: queues 16-bit commands and issues them
// one at a time to CommMaster, collecting ACK/read/dump response bytes.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | waiting for a queued command with no sticky error
//   S_WAIT_TX  | command sent, waiting for cmd_cmplt
//   S_WAIT_RSP | waiting for the single read-data or write ACK/NAK byte
//   S_DUMP     | streaming ENTRIES dump bytes
module la_cmd_sequencer #(
   parameter int DEPTH   = 8,
   parameter int ENTRIES = 384,
   parameter int TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_cmd,
   input  logic [15:0] cmd_in,
   output logic        full,
   output logic [15:0] cmd,
   output logic        snd_cmd,
   input  logic        cmd_cmplt,
   input  logic [7:0]  rec_data,
   input  logic        rec_rdy,
   output logic        clr_rec_rdy,
   output logic        busy,
   output logic        resp_vld,
   output logic [7:0]  resp_data,
   output logic        dump_vld,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        overflow,
   input  logic        clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT);
   localparam logic [15:0]   LAST_BYTE = 16'(ENTRIES - 1);
   localparam logic [1:0]    OP_WR  = 2'b01;
   localparam logic [1:0]    OP_DMP = 2'b10;
   localparam logic [1:0]    OP_RSV = 2'b11;
   localparam logic [7:0]    ACK    = 8'hA5;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_TX, S_WAIT_RSP, S_DUMP} state_t;

   state_t          state, state_nxt;
   logic [15:0]     fifo_mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, push, pop, launch, bad_op;
   logic [15:0]     fifo_head;
   logic            consume, progress, tmo, rsp_done, dump_last, set_err;
   logic [1:0]      set_code;
   logic [TW-1:0]   tmr;
   logic [15:0]     byte_cnt;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push      = wr_cmd && (!full || pop);
   assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];
   assign busy      = (state != S_IDLE);

   // Command FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_in;
   end

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a response byte or cmd_cmplt wins over a same-cycle timeout
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (launch) state_nxt = S_WAIT_TX;
         S_WAIT_TX:  if (cmd_cmplt) state_nxt = (cmd[15:14] == OP_DMP) ? S_DUMP : S_WAIT_RSP;
                     else if (tmo) state_nxt = S_IDLE;
         S_WAIT_RSP: if (consume || tmo) state_nxt = S_IDLE;
         S_DUMP:     if (dump_last || tmo) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Output/event decode for the current state
   always_comb begin
      pop       = 1'b0;
      launch    = 1'b0;
      bad_op    = 1'b0;
      progress  = 1'b0;
      rsp_done  = 1'b0;
      dump_last = 1'b0;
      tmo       = 1'b0;
      set_err   = 1'b0;
      set_code  = 2'b00;
      consume   = rec_rdy && !clr_rec_rdy && (state == S_WAIT_RSP || state == S_DUMP);
      case (state)
         S_IDLE: begin
            pop    = !empty && !err;
            launch = pop && (fifo_head[15:14] != OP_RSV);
            bad_op = pop && (fifo_head[15:14] == OP_RSV);
            if (bad_op) begin
               set_err  = 1'b1;
               set_code = 2'b11;
            end
         end
         S_WAIT_TX:  progress = cmd_cmplt;
         S_WAIT_RSP: begin
            progress = consume;
            rsp_done = consume;
            if (consume && cmd[15:14] == OP_WR && rec_data != ACK) begin
               set_err  = 1'b1;
               set_code = 2'b01;
            end
         end
         S_DUMP: begin
            progress  = consume;
            dump_last = consume && (byte_cnt == LAST_BYTE);
         end
         default: ;
      endcase
      if (state != S_IDLE && !progress && tmr == '0) begin
         tmo      = 1'b1;
         set_err  = 1'b1;
         set_code = 2'b10;
      end
   end

   // Idle-cycle down-counter, reloaded on every state change and every bit of progress
   always_ff @(posedge clk) begin
      if (rst)                                                  tmr <= '0;
      else if (state == S_IDLE || state_nxt != state || progress) tmr <= TMR_LOAD;
      else                                                      tmr <= tmr - TW'(1);
   end

   // Dump byte counter, held at zero outside DUMP so every dump starts fresh
   always_ff @(posedge clk) begin
      if (rst || state != S_DUMP) byte_cnt <= '0;
      else if (consume)           byte_cnt <= byte_cnt + 16'd1;
   end

   // Registered strobes, command/response holding registers and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd         <= '0;
         snd_cmd     <= 1'b0;
         clr_rec_rdy <= 1'b0;
         resp_vld    <= 1'b0;
         resp_data   <= '0;
         dump_vld    <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
         overflow    <= 1'b0;
      end else begin
         snd_cmd     <= launch;
         clr_rec_rdy <= consume;
         dump_vld    <= consume && (state == S_DUMP);
         resp_vld    <= bad_op || rsp_done || dump_last || tmo;
         if (launch)  cmd       <= fifo_head;
         if (consume) resp_data <= rec_data;
         if (clr_err) begin
            err      <= 1'b0;
            err_code <= 2'b00;
            overflow <= 1'b0;
         end else begin
            if (set_err && !err) begin
               err      <= 1'b1;
               err_code <= set_code;
            end
            if (wr_cmd && full && !pop) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// Bench for la_cmd_sequencer: a CommMaster responder model, a scoreboard of
// expected sends/dump bytes/responses, and directed plus random command mixes.
module tb_la_cmd_sequencer;

   localparam int DEPTH   = 8;
   localparam int ENTRIES = 384;
   localparam int TIMEOUT = 300;

   localparam int K_SND = 0, K_DUMP = 1, K_RESP = 2;
   localparam int M_OK = 0, M_NAK = 1, M_STALL = 2;

   typedef struct {
      int          kind;
      logic [15:0] val;
      bit          chk;
      bit          e_err;
      logic [1:0]  e_code;
      bit          tmo;
   } exp_t;

   typedef struct {
      int          kind;
      logic [7:0]  rbyte;
   } plan_t;

   logic        clk = 1'b0;
   logic        rst, wr_cmd, cmd_cmplt, rec_rdy, clr_err;
   logic [15:0] cmd_in;
   logic [7:0]  rec_data;
   logic        full, snd_cmd, clr_rec_rdy, busy, resp_vld, dump_vld, err, overflow;
   logic [15:0] cmd;
   logic [7:0]  resp_data;
   logic [1:0]  err_code;

   exp_t        expect_q [$];
   plan_t       plan_q [$];
   exp_t        mon_e;
   logic [7:0]  regs [64];
   int          checks = 0, errors = 0;
   int          outstanding = 0;
   int          cyc = 0, last_snd_cyc = 0;
   bit          abort = 0, clr_en = 0;

   la_cmd_sequencer #(.DEPTH(DEPTH), .ENTRIES(ENTRIES), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .cmd_in(cmd_in), .full(full),
      .cmd(cmd), .snd_cmd(snd_cmd), .cmd_cmplt(cmd_cmplt), .rec_data(rec_data),
      .rec_rdy(rec_rdy), .clr_rec_rdy(clr_rec_rdy), .busy(busy), .resp_vld(resp_vld),
      .resp_data(resp_data), .dump_vld(dump_vld), .err(err), .err_code(err_code),
      .overflow(overflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input int kind, input logic [15:0] val, input bit chk,
                           input bit e_err, input logic [1:0] e_code, input bit tmo);
      exp_t e;
      e.kind = kind; e.val = val; e.chk = chk; e.e_err = e_err; e.e_code = e_code; e.tmo = tmo;
      expect_q.push_back(e);
   endtask

   task automatic push_plan(input int kind, input logic [7:0] b);
      plan_t p;
      p.kind = kind; p.rbyte = b;
      plan_q.push_back(p);
   endtask

   // Push one command into the DUT and record what it should produce when it runs.
   task automatic issue(input logic [15:0] w, input int mode, input logic [7:0] nb, input bit drop);
      logic [1:0]  op;
      logic [5:0]  a;
      logic [15:0] last;
      op = w[15:14];
      a  = w[13:8];
      wr_cmd = 1'b1; cmd_in = w;
      @(negedge clk);
      wr_cmd = 1'b0;
      if (!drop) begin
         outstanding++;
         if (op == 2'b11) begin
            push_exp(K_RESP, 16'h0, 0, 1, 2'b11, 0);
         end else if (mode == M_STALL) begin
            push_exp(K_SND, w, 0, 0, 2'b00, 0);
            push_plan(M_STALL, 8'h00);
            push_exp(K_RESP, 16'h0, 0, 1, 2'b10, 1);
         end else if (op == 2'b10) begin
            push_exp(K_SND, w, 0, 0, 2'b00, 0);
            push_plan(M_OK, 8'h00);
            for (int i = 0; i < ENTRIES; i++) push_exp(K_DUMP, 16'(i % 256), 1, 0, 2'b00, 0);
            last = 16'((ENTRIES - 1) % 256);
            push_exp(K_RESP, last, 1, 0, 2'b00, 0);
         end else if (op == 2'b01) begin
            push_exp(K_SND, w, 0, 0, 2'b00, 0);
            if (mode == M_NAK) begin
               push_plan(M_OK, nb);
               push_exp(K_RESP, {8'h00, nb}, 1, 1, 2'b01, 0);
            end else begin
               push_plan(M_OK, 8'hA5);
               push_exp(K_RESP, 16'h00A5, 1, 0, 2'b00, 0);
               regs[a] = w[7:0];
            end
         end else begin
            push_exp(K_SND, w, 0, 0, 2'b00, 0);
            push_plan(M_OK, regs[a]);
            push_exp(K_RESP, {8'h00, regs[a]}, 1, 0, 2'b00, 0);
         end
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         if (outstanding == 0 && expect_q.size() == 0 && !busy) break;
         @(negedge clk);
      end
      if (k == budget) begin
         checks++; errors++;
         $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_cmd"}, 32'(cmd), 32'h0);
      check({tag, "_snd_cmd"}, 32'(snd_cmd), 32'h0);
      check({tag, "_clr_rec_rdy"}, 32'(clr_rec_rdy), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_resp_vld"}, 32'(resp_vld), 32'h0);
      check({tag, "_resp_data"}, 32'(resp_data), 32'h0);
      check({tag, "_dump_vld"}, 32'(dump_vld), 32'h0);
      check({tag, "_err"}, 32'(err), 32'h0);
      check({tag, "_err_code"}, 32'(err_code), 32'h0);
      check({tag, "_overflow"}, 32'(overflow), 32'h0);
      check({tag, "_full"}, 32'(full), 32'h0);
   endtask

   // Scoreboard monitor: every DUT strobe must match the head of the expectation queue
   always @(negedge clk) begin
      if (!rst) begin
         if (snd_cmd) begin
            if (expect_q.size() == 0 || expect_q[0].kind != K_SND) begin
               checks++; errors++;
               $display("FAIL snd_cmd: got unexpected send of %h, expected no send", cmd);
            end else begin
               mon_e = expect_q.pop_front();
               check("snd_cmd_word", 32'(cmd), 32'(mon_e.val));
               last_snd_cyc = cyc;
            end
         end
         if (dump_vld) begin
            if (expect_q.size() == 0 || expect_q[0].kind != K_DUMP) begin
               checks++; errors++;
               $display("FAIL dump_vld: got unexpected dump byte %h, expected none", resp_data);
            end else begin
               mon_e = expect_q.pop_front();
               check("dump_byte", 32'(resp_data), 32'(mon_e.val[7:0]));
            end
         end
         if (resp_vld) begin
            if (expect_q.size() == 0 || expect_q[0].kind != K_RESP) begin
               checks++; errors++;
               $display("FAIL resp_vld: got unexpected response %h, expected none", resp_data);
            end else begin
               mon_e = expect_q.pop_front();
               if (mon_e.chk) check("resp_data", 32'(resp_data), 32'(mon_e.val[7:0]));
               check("resp_err", 32'(err), 32'(mon_e.e_err));
               check("resp_err_code", 32'(err_code), 32'(mon_e.e_code));
               if (mon_e.tmo)
                  check("timeout_latency_in_window",
                        32'((cyc - last_snd_cyc) >= TIMEOUT && (cyc - last_snd_cyc) <= TIMEOUT + 2), 32'h1);
               outstanding--;
            end
         end
      end
   end

   // CommMaster model: completes transmission after a short delay and serves response bytes
   initial begin
      plan_t       p;
      logic [15:0] c;
      int          n;
      bit          ok;
      cmd_cmplt = 1'b0; rec_rdy = 1'b0; rec_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && snd_cmd) begin
            c = cmd;
            if (plan_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL dispatch_plan: got send of %h, expected no send", c);
               continue;
            end
            p = plan_q.pop_front();
            if (p.kind == M_STALL) continue;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (abort) continue;
            cmd_cmplt = 1'b1;
            @(negedge clk);
            cmd_cmplt = 1'b0;
            n = (c[15:14] == 2'b10) ? ENTRIES : 1;
            for (int i = 0; i < n && !abort; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               rec_data = (n > 1) ? 8'(i) : p.rbyte;
               rec_rdy  = 1'b1;
               ok = 0;
               for (int k = 0; k < 60 && !abort; k++) begin
                  @(negedge clk);
                  if (clr_rec_rdy) begin ok = 1; break; end
               end
               rec_rdy = 1'b0;
               if (!ok && !abort) begin
                  checks++; errors++;
                  $display("FAIL clr_rec_rdy: got no clear within 60 cycles, expected 1 cycle");
               end
            end
         end
      end
   end

   // Automatic error clearing used only during the random phase
   initial begin
      clr_err = 1'b0;
      forever begin
         @(negedge clk);
         if (clr_en && err && !rst) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish within time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cnt;
      logic [15:0] w;
      logic [7:0]  nb;
      int          r, mode;
      for (int i = 0; i < 64; i++) regs[i] = 8'h00;
      rst = 1'b1; wr_cmd = 1'b0; cmd_in = 16'h0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;
      @(negedge clk);

      // write with ACK, then read it back
      issue(16'h4780, M_OK, 8'h00, 0);
      wait_idle(200, "write_ack");
      check("write_ack_err", 32'(err), 32'h0);
      issue(16'h0700, M_OK, 8'h00, 0);
      wait_idle(200, "read_back");
      check("read_back_data", 32'(resp_data), 32'h80);

      // NAK blocks the next queued command until cleared
      issue(16'h4912, M_NAK, 8'hEE, 0);
      issue(16'h0700, M_OK, 8'h00, 0);
      cnt = 0;
      while (!err && cnt < 200) begin @(negedge clk); cnt++; end
      check("nak_err", 32'(err), 32'h1);
      check("nak_err_code", 32'(err_code), 32'h1);
      cnt = 0;
      repeat (20) begin @(negedge clk); if (snd_cmd || busy) cnt++; end
      check("blocked_while_err", 32'(cnt), 32'h0);
      pulse_clr();
      wait_idle(200, "after_nak_clear");
      check("nak_cleared_err", 32'(err), 32'h0);

      // full dump of channel 3
      issue(16'h8300, M_OK, 8'h00, 0);
      wait_idle(20000, "dump_ch3");

      // CommMaster never completes: timeout
      issue(16'h0100, M_STALL, 8'h00, 0);
      wait_idle(TIMEOUT + 100, "timeout");
      check("timeout_err_code", 32'(err_code), 32'h2);
      pulse_clr();

      // clr_err mid-command leaves the command running
      issue(16'h0700, M_OK, 8'h00, 0);
      cnt = 0;
      while (!busy && cnt < 20) begin @(negedge clk); cnt++; end
      pulse_clr();
      wait_idle(200, "clr_mid_cmd");

      // reserved op holds err; fill the FIFO past DEPTH
      issue(16'hC555, M_OK, 8'h00, 0);
      wait_idle(50, "reserved_op");
      check("reserved_err_code", 32'(err_code), 32'h3);
      for (int i = 0; i < DEPTH; i++) begin
         w = {1'b0, i[0], 6'(i + 10), 8'(8'h30 + i)};
         issue(w, M_OK, 8'h00, 0);
      end
      check("full_at_depth", 32'(full), 32'h1);
      check("no_overflow_at_depth", 32'(overflow), 32'h0);
      issue(16'h4A99, M_OK, 8'h00, 1);
      check("overflow_set", 32'(overflow), 32'h1);
      check("still_full", 32'(full), 32'h1);
      pulse_clr();
      check("overflow_cleared", 32'(overflow), 32'h0);
      wait_idle(2000, "drain_after_overflow");

      // random mix against the model
      clr_en = 1;
      for (int n = 0; n < 40; n++) begin
         cnt = 0;
         while (outstanding >= DEPTH && cnt < 30000) begin @(negedge clk); cnt++; end
         r    = $urandom_range(0, 99);
         mode = M_OK;
         nb   = 8'h00;
         if (r < 35) begin
            w = {2'b00, 6'($urandom_range(0, 63)), 8'h00};
         end else if (r < 70) begin
            w = {2'b01, 6'($urandom_range(0, 63)), 8'($urandom)};
            if ($urandom_range(0, 3) == 0) begin
               mode = M_NAK;
               nb = ($urandom_range(0, 1) == 0) ? 8'hEE : 8'($urandom);
               if (nb == 8'hA5) nb = 8'h5A;
            end
         end else if (r < 80) begin
            w = {2'b10, 3'b000, 3'($urandom_range(0, 7)), 8'h00};
         end else if (r < 88) begin
            w = {2'b11, 14'($urandom)};
         end else begin
            w = {2'b00, 6'($urandom_range(0, 63)), 8'h00};
            mode = M_STALL;
         end
         issue(w, mode, nb, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(60000, "random_drain");
      clr_en = 0;
      @(negedge clk);
      if (err) pulse_clr();
      check("expect_queue_drained", 32'(expect_q.size()), 32'h0);
      check("plan_queue_drained", 32'(plan_q.size()), 32'h0);

      // reset in the middle of a dump drops everything
      issue(16'h8500, M_OK, 8'h00, 0);
      issue(16'h0300, M_OK, 8'h00, 0);
      issue(16'h0400, M_OK, 8'h00, 0);
      cnt = 0;
      r = 0;
      while (cnt < 10 && r < 2000) begin @(negedge clk); if (dump_vld) cnt++; r++; end
      check("dump_started_before_reset", 32'(cnt), 32'd10);
      rst = 1'b1; abort = 1;
      expect_q.delete(); plan_q.delete(); outstanding = 0;
      @(negedge clk);
      check_quiet("mid_dump_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      abort = 0;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (snd_cmd || busy || clr_rec_rdy) cnt++; end
      check("fifo_dropped_by_reset", 32'(cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
